max_pool: RTL and testbench



---
 rtl/max_pool.sv | 114 +++++++++++
 tb/tb_max_pool.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool.sv
`default_nettype none
// ============================================================================
// Module   : max_pool
// Purpose  : Per-filter running signed maximum over POOL_LEN frame positions
//            of a time-major / filter-minor sample stream; emits one packed
//            vector of NUM_FILTERS values per pooling window.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool #(
  parameter int BW          = 8,
  parameter int NUM_FILTERS = 8,
  parameter int POOL_LEN    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [BW-1:0]          data_i,
  input  logic                          valid_i,
  input  logic                          last_i,
  output logic                          ready_o,
  output logic [NUM_FILTERS*BW-1:0]     data_o,
  output logic                          valid_o,
  output logic                          last_o,
  input  logic                          ready_i
);

  // Counter widths stay at least one bit so degenerate sizes still elaborate.
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int PW = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;

  logic [FW-1:0]              filt_cnt;
  logic [PW-1:0]              pool_cnt;
  logic signed [BW-1:0]       max_q [NUM_FILTERS];
  logic signed [BW-1:0]       cur_max;
  logic signed [BW-1:0]       new_val;
  logic [NUM_FILTERS*BW-1:0]  pool_vec;
  logic                       accept;
  logic                       filt_last;
  logic                       pool_last;
  logic                       flush;

  // No skid buffer: the input is stalled only while an unread vector is held.
  assign ready_o   = !valid_o || ready_i;
  assign accept    = valid_i && ready_o;
  assign filt_last = (filt_cnt == FW'(NUM_FILTERS - 1));
  assign pool_last = (pool_cnt == PW'(POOL_LEN - 1));
  // last_i always closes the window, even mid-position (stale elements remain).
  assign flush     = accept && (last_i || (filt_last && pool_last));

  // Running max of the filter currently being presented.
  always_comb begin
    cur_max = max_q[0];
    for (int f = 0; f < NUM_FILTERS; f++) begin
      if (filt_cnt == FW'(f)) cur_max = max_q[f];
    end
  end

  // First position of a window loads outright; later ones take the signed max.
  assign new_val = (pool_cnt == '0) ? data_i
                 : ((cur_max > data_i) ? cur_max : data_i);

  // Outgoing vector: stored maxima with the in-flight sample merged in.
  always_comb begin
    pool_vec = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      pool_vec[f*BW +: BW] = (filt_cnt == FW'(f)) ? new_val : max_q[f];
    end
  end

  // Running-max registers, one per filter, updated on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int f = 0; f < NUM_FILTERS; f++) max_q[f] <= '0;
    end else if (accept) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        if (filt_cnt == FW'(f)) max_q[f] <= new_val;
      end
    end
  end

  // Filter / window position counters; a flush restarts both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_cnt <= '0;
      pool_cnt <= '0;
    end else if (flush) begin
      filt_cnt <= '0;
      pool_cnt <= '0;
    end else if (accept) begin
      if (filt_last) begin
        filt_cnt <= '0;
        pool_cnt <= pool_cnt + PW'(1);
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Output register: loads on window completion, holds until consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (flush) begin
      data_o  <= pool_vec;
      valid_o <= 1'b1;
      last_o  <= last_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool
// Purpose  : Self-checking bench for max_pool (2x2 and 8x4 configurations)
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool;
  localparam int BW  = 8;
  localparam int NFA = 2;
  localparam int PLA = 2;
  localparam int NFB = 8;
  localparam int PLB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Configuration A: 2 filters, window of 2
  logic signed [BW-1:0]   a_data = '0;
  logic                   a_valid = 1'b0;
  logic                   a_last = 1'b0;
  logic                   a_ready_o;
  logic [NFA*BW-1:0]      a_dout;
  logic                   a_vout;
  logic                   a_lout;
  logic                   a_ready_i = 1'b1;

  // Configuration B: 8 filters, window of 4
  logic signed [BW-1:0]   b_data = '0;
  logic                   b_valid = 1'b0;
  logic                   b_last = 1'b0;
  logic                   b_ready_o;
  logic [NFB*BW-1:0]      b_dout;
  logic                   b_vout;
  logic                   b_lout;
  logic                   b_ready_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  max_pool #(.BW(BW), .NUM_FILTERS(NFA), .POOL_LEN(PLA)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .valid_i(a_valid), .last_i(a_last),
    .ready_o(a_ready_o), .data_o(a_dout), .valid_o(a_vout), .last_o(a_lout),
    .ready_i(a_ready_i)
  );

  max_pool #(.BW(BW), .NUM_FILTERS(NFB), .POOL_LEN(PLB)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .valid_i(b_valid), .last_i(b_last),
    .ready_o(b_ready_o), .data_o(b_dout), .valid_o(b_vout), .last_o(b_lout),
    .ready_i(b_ready_i)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model for configuration A ----------------
  int                     m_f = 0;
  int                     m_p = 0;
  logic signed [BW-1:0]   win [PLA][NFA];
  logic [NFA*BW:0]        exp_q [$];   // {last, vector}

  function automatic void model_accept(input logic signed [BW-1:0] d, input logic l);
    logic signed [BW-1:0] mx;
    logic [NFA*BW-1:0]    v;
    win[m_p][m_f] = d;
    if (m_f == NFA - 1) begin
      if (m_p == PLA - 1 || l) begin
        v = '0;
        for (int f = 0; f < NFA; f++) begin
          mx = win[0][f];
          for (int p = 1; p <= m_p; p++) if (win[p][f] > mx) mx = win[p][f];
          v[f*BW +: BW] = mx;
        end
        exp_q.push_back({l, v});
        m_p = 0;
      end else begin
        m_p++;
      end
      m_f = 0;
    end else begin
      m_f++;
    end
  endfunction

  // Present one sample on A until it is accepted (bounded), then log it.
  task automatic push(input logic signed [BW-1:0] d, input logic l);
    bit acc;
    int guard;
    guard = 0;
    a_data = d; a_last = l; a_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = a_ready_o;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    if (acc) model_accept(d, l);
    else check_val("push_timeout", 64'd0, 64'd1);
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  // Scoreboard and hold-stability monitor for A.
  logic [NFA*BW-1:0] hold_data;
  logic              hold_last;
  bit                hold = 1'b0;
  logic [NFA*BW:0]   e;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check_val("hold_valid", 64'(a_vout), 64'd1);
        check_val("hold_data", 64'(a_dout), 64'(hold_data));
        check_val("hold_last", 64'(a_lout), 64'(hold_last));
      end
      if (a_vout && a_ready_i) begin
        if (exp_q.size() == 0) check_val("unexpected_vec", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check_val("vec_data", 64'(a_dout), 64'(e[NFA*BW-1:0]));
          check_val("vec_last", 64'(a_lout), 64'(e[NFA*BW]));
        end
      end
      hold      = a_vout && !a_ready_i;
      hold_data = a_dout;
      hold_last = a_lout;
    end
  end

  logic signed [BW-1:0] bsamp [64];
  bit                   rnd_done = 1'b0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(a_vout), 64'd0);
    check_val("rst_last", 64'(a_lout), 64'd0);
    check_val("rst_data", 64'(a_dout), 64'd0);
    check_val("rst_ready", 64'(a_ready_o), 64'd1);
    rst = 1'b0;

    // Basic window, one-cycle latency, valid drops after consumption
    a_ready_i = 1'b1;
    push(8'sd3, 1'b0); push(-8'sd5, 1'b0); push(8'sd7, 1'b0); push(-8'sd9, 1'b0);
    check_val("t1_valid", 64'(a_vout), 64'd1);
    check_val("t1_data", 64'(a_dout), 64'hFB07);
    check_val("t1_last", 64'(a_lout), 64'd0);
    @(posedge clk); #1;
    check_val("t1_drop", 64'(a_vout), 64'd0);

    // Backpressure: output held, input stalled, ready returns with ready_i
    a_ready_i = 1'b0;
    push(8'sd3, 1'b0); push(-8'sd5, 1'b0); push(8'sd7, 1'b0); push(-8'sd9, 1'b0);
    check_val("t2_data", 64'(a_dout), 64'hFB07);
    a_data = 8'sd2; a_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("t2_stall", 64'(a_ready_o), 64'd0);
      check_val("t2_hold", 64'(a_dout), 64'hFB07);
    end
    @(posedge clk); #1;
    a_ready_i = 1'b1;
    #1;
    check_val("t2_ready", 64'(a_ready_o), 64'd1);
    push(8'sd2, 1'b0); push(-8'sd1, 1'b0); push(8'sd4, 1'b0); push(8'sd1, 1'b0);
    check_val("t2_vec", 64'(a_dout), 64'h0104);

    // Partial window closed by last_i
    push(8'sd1, 1'b0); push(8'sd1, 1'b0); push(8'sd2, 1'b0); push(8'sd0, 1'b0);
    check_val("t3_vec1", 64'(a_dout), 64'h0102);
    check_val("t3_last1", 64'(a_lout), 64'd0);
    push(8'sd4, 1'b0); push(8'sd2, 1'b1);
    check_val("t3_vec2", 64'(a_dout), 64'h0204);
    check_val("t3_last2", 64'(a_lout), 64'd1);

    // Negative extremes: no zero floor
    repeat (4) push(-8'sd128, 1'b0);
    check_val("t4_min", 64'(a_dout), 64'h8080);
    push(-8'sd1, 1'b0); push(8'sd5, 1'b0); push(-8'sd3, 1'b0); push(8'sd6, 1'b0);
    check_val("t4_neg", 64'(a_dout), 64'h06FF);

    // Reset mid-window discards the partial window
    push(8'sd50, 1'b0); push(8'sd50, 1'b0); push(8'sd50, 1'b0);
    rst = 1'b1;
    #1;
    check_val("t5_rst_valid", 64'(a_vout), 64'd0);
    check_val("t5_rst_data", 64'(a_dout), 64'd0);
    m_f = 0; m_p = 0; exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_val("t5_rst_hold", 64'(a_vout), 64'd0);
    rst = 1'b0;
    push(8'sd9, 1'b0); push(8'sd8, 1'b0); push(8'sd1, 1'b0); push(8'sd1, 1'b0);
    check_val("t5_vec", 64'(a_dout), 64'h0809);
    check_val("t5_last", 64'(a_lout), 64'd0);

    // Random stream with random gaps, random backpressure and random last_i
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          push(BW'($urandom), (m_f == NFA - 1) && ($urandom_range(0, 4) == 0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          a_ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join
    a_ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("rnd_drain", 64'(exp_q.size()), 64'd0);

    // 8 filters x window 4, continuous stream at full rate
    for (int i = 0; i < 64; i++) bsamp[i] = BW'($urandom);
    bsamp[5] = -8'sd128;
    b_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      b_data = bsamp[i]; b_valid = 1'b1;
      @(negedge clk);
      check_val("t6_ready", 64'(b_ready_o), 64'd1);
      @(posedge clk); #1;
      if (i % 32 == 31) begin
        logic [NFB*BW-1:0]    ref_v;
        logic signed [BW-1:0] mx;
        int                   base;
        base = (i / 32) * 32;
        for (int f = 0; f < NFB; f++) begin
          mx = bsamp[base + f];
          for (int p = 1; p < PLB; p++) if (bsamp[base + p*NFB + f] > mx) mx = bsamp[base + p*NFB + f];
          ref_v[f*BW +: BW] = mx;
        end
        check_val("t6_pulse", 64'(b_vout), 64'd1);
        check_val("t6_data", 64'(b_dout), 64'(ref_v));
        check_val("t6_last", 64'(b_lout), 64'd0);
      end else begin
        check_val("t6_idle", 64'(b_vout), 64'd0);
      end
    end
    b_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
`default_nettype wire
